// File: rtl/roller_pkg.sv
// Shared definitions for the scrolling-digit engine: state encoding, default
// geometry and the wrap-around position stepper.
package roller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } roller_state_e;

   localparam int DEF_DIGITS  = 4;
   localparam int DEF_SEQ_LEN = 12;
   localparam int DEF_NSEQ    = 2;
   localparam int DEF_DW      = 4;

   // One step around a ring of len positions, forward or backward.
   function automatic int unsigned mod_step(input int unsigned pos,
                                            input int unsigned len,
                                            input logic        down);
      int unsigned res;
      if (down) begin
         if (pos == 32'd0) res = len - 32'd1;
         else              res = pos - 32'd1;
      end else begin
         if (pos >= len - 32'd1) res = 32'd0;
         else                    res = pos + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/roller_bank.sv
// Digit sequence storage: NSEQ banks of SEQ_LEN digits, one synchronous write
// port and a DIGITS-wide combinational window read starting at head.
module roller_bank
   import roller_pkg::*;
#(
   parameter  int DIGITS  = DEF_DIGITS,
   parameter  int SEQ_LEN = DEF_SEQ_LEN,
   parameter  int NSEQ    = DEF_NSEQ,
   parameter  int DW      = DEF_DW,
   localparam int SW      = (NSEQ > 1) ? $clog2(NSEQ) : 1,
   localparam int AW      = $clog2(SEQ_LEN)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [SW-1:0]          wr_bank,
   input  logic [AW-1:0]          wr_addr,
   input  logic [DW-1:0]          wr_data,
   input  logic [SW-1:0]          sel,
   input  logic [AW-1:0]          head,
   output logic [DIGITS*DW-1:0]   window
);

   logic [DW-1:0] mem_r [NSEQ][SEQ_LEN];
   logic          wr_ok_s;
   logic [SW-1:0] bank_s;

   // Qualify writes and bank selection against the real array bounds.
   always_comb begin
      wr_ok_s = wr_en && (int'(wr_bank) < NSEQ) && (int'(wr_addr) < SEQ_LEN);
      bank_s  = (int'(sel) < NSEQ) ? sel : '0;
   end

   // Register file with clear-on-reset; a write during reset is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NSEQ; b++) begin
            for (int a = 0; a < SEQ_LEN; a++) begin
               mem_r[b][a] <= '0;
            end
         end
      end else if (wr_ok_s) begin
         mem_r[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Window read: digit k comes from position (head+k) mod SEQ_LEN, leftmost in MSBs.
   always_comb begin
      int raw_v;
      int idx_v;
      window = '0;
      for (int k = 0; k < DIGITS; k++) begin
         raw_v = int'(head) + k;
         idx_v = (raw_v >= SEQ_LEN) ? (raw_v - SEQ_LEN) : raw_v;
         window[(DIGITS-1-k)*DW +: DW] = mem_r[bank_s][AW'(idx_v)];
      end
   end

endmodule

// File: rtl/digit_roller_n.sv
// Scrolling-digit engine top: run/pause/idle control, head counter, wrap pulse
// and registered window output. Define ROLLER_REVERSE_EN to add the dir input.
module digit_roller_n
   import roller_pkg::*;
#(
   parameter  int DIGITS  = DEF_DIGITS,
   parameter  int SEQ_LEN = DEF_SEQ_LEN,
   parameter  int NSEQ    = DEF_NSEQ,
   parameter  int DW      = DEF_DW,
   localparam int SW      = (NSEQ > 1) ? $clog2(NSEQ) : 1,
   localparam int AW      = $clog2(SEQ_LEN)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear,
   input  logic [SW-1:0]        sel,
   input  logic                 wr_en,
   input  logic [SW-1:0]        wr_bank,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DW-1:0]        wr_data,
   output logic [DIGITS*DW-1:0] digits,
   output logic                 running,
   output logic                 wrap
`ifdef ROLLER_REVERSE_EN
   ,
   input  logic                 dir
`endif
);

   roller_state_e          state_r;
   logic [AW-1:0]          head_r;
   logic                   wrap_r;
   logic                   running_r;
   logic [DIGITS*DW-1:0]   digits_r;
   logic [DIGITS*DW-1:0]   window_s;
   logic [AW-1:0]          step_s;
   logic                   wraps_s;
   logic                   dir_s;

`ifdef ROLLER_REVERSE_EN
   assign dir_s = dir;
`else
   assign dir_s = 1'b0;
`endif

   roller_bank #(
      .DIGITS  (DIGITS),
      .SEQ_LEN (SEQ_LEN),
      .NSEQ    (NSEQ),
      .DW      (DW)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .sel     (sel),
      .head    (head_r),
      .window  (window_s)
   );

   // Candidate head for this tick and whether taking it crosses the ring seam.
   always_comb begin
      step_s  = AW'(mod_step(32'(head_r), 32'(SEQ_LEN), dir_s));
      wraps_s = dir_s ? (head_r == '0) : (32'(head_r) == 32'(SEQ_LEN - 1));
   end

   // Control FSM with head, wrap and running kept as registered outputs; stop beats start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         head_r    <= '0;
         wrap_r    <= 1'b0;
         running_r <= 1'b0;
      end else if (clear) begin
         state_r   <= ST_IDLE;
         head_r    <= '0;
         wrap_r    <= 1'b0;
         running_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               head_r <= '0;
               wrap_r <= 1'b0;
               if (start && !stop) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end else begin
                  running_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_r   <= ST_PAUSE;
                  running_r <= 1'b0;
                  wrap_r    <= 1'b0;
               end else if (tick) begin
                  head_r    <= step_s;
                  wrap_r    <= wraps_s;
                  running_r <= 1'b1;
               end else begin
                  wrap_r    <= 1'b0;
                  running_r <= 1'b1;
               end
            end
            ST_PAUSE: begin
               wrap_r <= 1'b0;
               if (start && !stop) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end else begin
                  running_r <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               head_r    <= '0;
               wrap_r    <= 1'b0;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   // Window output register: one cycle behind head, sel and bank contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) digits_r <= '0;
      else       digits_r <= window_s;
   end

   assign digits  = digits_r;
   assign running = running_r;
   assign wrap    = wrap_r;

endmodule

// File: tb/tb_digit_roller_n.sv
// Directed bench for digit_roller_n: a ring-position model checked every cycle,
// plus literal window values worked out by hand from the loaded sequences.
module tb_digit_roller_n;

   localparam int DIGITS  = 4;
   localparam int SEQ_LEN = 12;
   localparam int NSEQ    = 2;
   localparam int DW      = 4;
   localparam int OW      = DIGITS * DW;

   logic          clk = 1'b0;
   logic          reset, tick, start, stop, clear, wr_en, dir;
   logic [0:0]    sel, wr_bank;
   logic [3:0]    wr_addr;
   logic [3:0]    wr_data;
   logic [OW-1:0] digits;
   logic          running, wrap;

   int total = 0;
   int bad   = 0;

   // model: ring contents, position and mode as plain numbers
   int            m_bank [NSEQ][SEQ_LEN];
   int            m_head;
   int            m_mode;           // 0 idle, 1 run, 2 pause
   logic [OW-1:0] exp_digits;
   logic          exp_running, exp_wrap;

   int seq0 [SEQ_LEN] = '{5, 2, 3, 3, 7, 0, 9, 1, 0, 2, 1, 7};

   digit_roller_n #(.DIGITS(DIGITS), .SEQ_LEN(SEQ_LEN), .NSEQ(NSEQ), .DW(DW)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
      .clear(clear), .sel(sel), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_addr(wr_addr), .wr_data(wr_data), .digits(digits),
      .running(running), .wrap(wrap)
`ifdef ROLLER_REVERSE_EN
      , .dir(dir)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic logic [OW-1:0] win(input int h, input int s);
      logic [OW-1:0] w;
      w = '0;
      for (int k = 0; k < DIGITS; k++)
         w = (w << DW) | OW'(m_bank[s][(h + k) % SEQ_LEN]);
      return w;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NSEQ; b++)
         for (int a = 0; a < SEQ_LEN; a++) m_bank[b][a] = 0;
      m_head = 0; m_mode = 0;
      exp_digits = '0; exp_running = 1'b0; exp_wrap = 1'b0;
   endtask

   task automatic model_edge();
      logic [OW-1:0] pre;
      logic adv, w, back;
      if (reset) begin
         model_reset();
         return;
      end
      pre = win(m_head, int'(sel));
      adv = 1'b0; w = 1'b0; back = 1'b0;
`ifdef ROLLER_REVERSE_EN
      back = dir;
`endif
      if (clear) begin
         m_mode = 0; m_head = 0;
      end else if (m_mode == 1) begin
         if (stop) m_mode = 2;
         else if (tick) adv = 1'b1;
      end else if (start && !stop) begin
         m_mode = 1;
      end
      if (adv) begin
         if (!back) begin
            w = (m_head + 1 == SEQ_LEN);
            m_head = (m_head + 1) % SEQ_LEN;
         end else begin
            w = (m_head == 0);
            m_head = (m_head + SEQ_LEN - 1) % SEQ_LEN;
         end
      end
      if (wr_en && int'(wr_bank) < NSEQ && int'(wr_addr) < SEQ_LEN)
         m_bank[wr_bank][wr_addr] = int'(wr_data);
      exp_digits = pre; exp_wrap = w; exp_running = (m_mode == 1);
   endtask

   // Every cycle: outputs must match the model.
   always @(negedge clk) begin
      chk("digits_model", 32'(digits), 32'(exp_digits));
      chk("running_model", 32'(running), 32'(exp_running));
      chk("wrap_model", 32'(wrap), 32'(exp_wrap));
   end

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input int b, input int a, input int d);
      wr_en = 1'b1; wr_bank = 1'(b); wr_addr = 4'(a); wr_data = 4'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) cyc();
      tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
      wr_en = 1'b0; dir = 1'b0; sel = 1'b0; wr_bank = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
      model_reset();
      repeat (2) cyc();
      chk("reset_digits", 32'(digits), 32'h0000);
      chk("reset_running", 32'(running), 32'd0);
      reset = 1'b0;
      cyc();

      // load both banks; bank1 differs only at position 11
      for (int a = 0; a < SEQ_LEN; a++) wr(0, a, seq0[a]);
      for (int a = 0; a < SEQ_LEN; a++) wr(1, a, (a == 11) ? 8 : seq0[a]);

      // start with a coincident tick: no advance
      start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0;
      ticks(1); cyc();
      chk("first_tick", 32'(digits), 32'h2337);
      ticks(11);
      chk("wrap_pulse", 32'(wrap), 32'd1);
      cyc();
      chk("wrap_drop", 32'(wrap), 32'd0);
      chk("full_loop", 32'(digits), 32'h5233);

      ticks(9); cyc();
      chk("head9", 32'(digits), 32'h2175);
      sel = 1'b1; cyc();
      chk("sel_bank1", 32'(digits), 32'h2185);
      chk("sel_running", 32'(running), 32'd1);
      sel = 1'b0;

      // stop beats start
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      chk("pause_running", 32'(running), 32'd0);
      ticks(3);
      chk("pause_frozen", 32'(digits), 32'h2175);
      start = 1'b1; cyc(); start = 1'b0;
      ticks(1); cyc();
      chk("resume", 32'(digits), 32'h1752);
      clear = 1'b1; cyc(); clear = 1'b0;
      cyc();
      chk("clear_digits", 32'(digits), 32'h5233);
      chk("clear_running", 32'(running), 32'd0);

      start = 1'b1; cyc(); start = 1'b0;
      wr(0, 2, 15); cyc();
      chk("visible_write", 32'(digits), 32'h52F3);
      wr(0, 12, 0); cyc();
      chk("oob_write", 32'(digits), 32'h52F3);

      // reset at head 5 with a coincident write
      ticks(5);
      reset = 1'b1; wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'd0; wr_data = 4'd9;
      model_reset();
      #1;
      chk("midrun_rst_digits", 32'(digits), 32'h0000);
      chk("midrun_rst_running", 32'(running), 32'd0);
      chk("midrun_rst_wrap", 32'(wrap), 32'd0);
      cyc();
      wr_en = 1'b0; reset = 1'b0;
      wr(0, 1, 6);
      ticks(1); cyc();
      chk("idle_tick_ignored", 32'(digits), 32'h0600);
      chk("idle_running", 32'(running), 32'd0);

`ifdef ROLLER_REVERSE_EN
      for (int a = 0; a < SEQ_LEN; a++) wr(0, a, seq0[a]);
      start = 1'b1; cyc(); start = 1'b0;
      dir = 1'b1; ticks(1);
      chk("rev_wrap", 32'(wrap), 32'd1);
      cyc(); dir = 1'b0;
      chk("rev_digits", 32'(digits), 32'h7523);
`endif

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
